// File: rtl/reg_scoreboard_file_if.sv
// Bundles the read, write, link and issue/scoreboard signals of the register file.
interface reg_scoreboard_file_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic [ADDR_W-1:0] rd_addr1;
  logic [ADDR_W-1:0] rd_addr2;
  logic [DATA_W-1:0] rd_data1;
  logic [DATA_W-1:0] rd_data2;
  logic              we;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              link_we;
  logic [DATA_W-1:0] link_data;
  logic [DATA_W-1:0] link_value;
  logic              issue_valid;
  logic [ADDR_W-1:0] issue_dst;
  logic              busy1;
  logic              busy2;
  logic              stall;

  modport master (
    output rd_addr1, rd_addr2, we, wr_addr, wr_data, link_we, link_data,
           issue_valid, issue_dst,
    input  rd_data1, rd_data2, link_value, busy1, busy2, stall
  );

  modport slave (
    input  rd_addr1, rd_addr2, we, wr_addr, wr_data, link_we, link_data,
           issue_valid, issue_dst,
    output rd_data1, rd_data2, link_value, busy1, busy2, stall
  );
endinterface

// File: rtl/reg_scoreboard_file.sv
// Two-read register file with a link-register write port, optional same-cycle
// forwarding and a per-register busy scoreboard for issue stalls.
module reg_scoreboard_file #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int LINK_REG = 31,
  parameter int BYPASS   = 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  reg_scoreboard_file_if.slave bus
);
  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LINK_ADDR = ADDR_W'(LINK_REG);

  logic [DATA_W-1:0] mem_reg [DEPTH];
  logic [DEPTH-1:0]  busy_reg;
  logic [DATA_W-1:0] link_value_reg;
  logic              wr_hit;
  logic [ADDR_W-1:0] rd_addr [2];

  assign wr_hit     = bus.we && (bus.wr_addr != '0);
  assign rd_addr[0] = bus.rd_addr1;
  assign rd_addr[1] = bus.rd_addr2;

  // Entry 0 is only ever reset, so it stays zero; the loops start at 1.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_reg[i] <= '0;
      end
      busy_reg       <= '0;
      link_value_reg <= '0;
    end else begin
      for (int i = 1; i < DEPTH; i++) begin
        if (bus.link_we && (ADDR_W'(i) == LINK_ADDR)) begin
          mem_reg[i] <= bus.link_data;
        end else if (wr_hit && (bus.wr_addr == ADDR_W'(i))) begin
          mem_reg[i] <= bus.wr_data;
        end
        // A new producer issued at the same edge outranks the completing write.
        if (bus.issue_valid && (bus.issue_dst == ADDR_W'(i))) begin
          busy_reg[i] <= 1'b1;
        end else if ((wr_hit && (bus.wr_addr == ADDR_W'(i))) ||
                     (bus.link_we && (ADDR_W'(i) == LINK_ADDR))) begin
          busy_reg[i] <= 1'b0;
        end
      end
      if (bus.link_we) begin
        link_value_reg <= bus.link_data;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_rd
      logic              link_match;
      logic              wr_match;
      logic [DATA_W-1:0] data_next;
      logic              busy_next;

      always_comb begin
        link_match = bus.link_we && (rd_addr[gi] == LINK_ADDR);
        wr_match   = wr_hit && (bus.wr_addr == rd_addr[gi]);
        data_next  = '0;
        busy_next  = 1'b0;
        if (reset_n && (rd_addr[gi] != '0)) begin
          if ((BYPASS != 0) && link_match) begin
            data_next = bus.link_data;
          end else if ((BYPASS != 0) && wr_match) begin
            data_next = bus.wr_data;
          end else begin
            data_next = mem_reg[rd_addr[gi]];
          end
          busy_next = busy_reg[rd_addr[gi]] &&
                      !((BYPASS != 0) && (link_match || wr_match));
        end
      end
    end
  endgenerate

  assign bus.rd_data1   = g_rd[0].data_next;
  assign bus.rd_data2   = g_rd[1].data_next;
  assign bus.busy1      = g_rd[0].busy_next;
  assign bus.busy2      = g_rd[1].busy_next;
  assign bus.stall      = g_rd[0].busy_next | g_rd[1].busy_next;
  assign bus.link_value = link_value_reg;
endmodule
